rem_issue_ctrl: RTL and testbench



---
 rtl/rem_issue_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_rem_issue_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rem_issue_ctrl.sv
// rem_issue_ctrl: issue/control stage in front of the iterative remainder unit.
// Accepts REM/REMU requests, holds operands stable for the unit, returns the
// result over a valid/ready channel and short-circuits repeated operations
// through a one-entry result cache. A watchdog traps a unit that never completes.
module rem_issue_ctrl #(
  parameter bit          CACHE_EN    = 1'b1,
  parameter int unsigned WDOG_CYCLES = 63
) (
  input  logic        clk_i,
  input  logic        rst_ni,

  // request channel from ID
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_op_a_i,
  input  logic [31:0] req_op_b_i,
  input  logic        req_signed_i,
  input  logic        flush_i,

  // response channel
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_result_o,
  output logic        err_o,

  // remainder unit interface
  output logic        rem_en_o,
  output logic [1:0]  rem_signed_mode_o,
  output logic [31:0] rem_op_a_o,
  output logic [31:0] rem_op_b_o,
  output logic        rem_equal_to_zero_o,
  input  logic [32:0] rem_alu_operand_a_i,
  input  logic [32:0] rem_alu_operand_b_i,
  output logic [33:0] rem_alu_adder_ext_o,
  output logic [31:0] rem_alu_adder_o,
  input  logic [31:0] rem_result_i,
  input  logic        rem_valid_i
);

  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE,
    BUSY,
    DRAIN,
    RESP,
    ERR
  } state_t;

  state_t              state;

  // latched operands driven to the remainder unit
  logic [31:0]         op_a;
  logic [31:0]         op_b;
  logic                op_signed;

  // one-entry result cache
  logic                cache_valid;
  logic [31:0]         cache_a;
  logic [31:0]         cache_b;
  logic                cache_signed;
  logic [31:0]         cache_result;

  // registered FSM outputs
  logic                rem_en;
  logic                rsp_valid;
  logic [31:0]         rsp_result;
  logic                err;

  logic [WDOG_W-1:0]   wdog_cnt;
  logic [WDOG_W-1:0]   wdog_next;
  logic                wdog_expire;

  logic                accept;
  logic                cache_hit;
  logic                unit_done;

  // Handshake, cache lookup and watchdog next-count decode
  always_comb begin
    req_ready_o = (state == IDLE) && !flush_i;
    accept      = req_valid_i && req_ready_o;
    cache_hit   = CACHE_EN && cache_valid &&
                  (req_op_a_i == cache_a) &&
                  (req_op_b_i == cache_b) &&
                  (req_signed_i == cache_signed);
    unit_done   = rem_valid_i && ((state == BUSY) || (state == DRAIN));
    wdog_next   = (wdog_cnt == WDOG_W'(WDOG_CYCLES)) ? wdog_cnt
                                                     : wdog_cnt + WDOG_W'(1);
    wdog_expire = (wdog_next == WDOG_W'(WDOG_CYCLES)) && !rem_valid_i;
  end

  // Operand latch: captured on every accepted request and held for the unit
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_a      <= '0;
      op_b      <= '0;
      op_signed <= 1'b0;
    end else if (accept) begin
      op_a      <= req_op_a_i;
      op_b      <= req_op_b_i;
      op_signed <= req_signed_i;
    end
  end

  // Cache refill whenever the unit completes, even for a flushed operation
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cache_valid  <= 1'b0;
      cache_a      <= '0;
      cache_b      <= '0;
      cache_signed <= 1'b0;
      cache_result <= '0;
    end else if (unit_done) begin
      cache_valid  <= 1'b1;
      cache_a      <= op_a;
      cache_b      <= op_b;
      cache_signed <= op_signed;
      cache_result <= rem_result_i;
    end
  end

  // Control FSM with registered enable, response and error outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      rem_en     <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      err        <= 1'b0;
      wdog_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (cache_hit) begin
              rsp_result <= cache_result;
              rsp_valid  <= 1'b1;
              state      <= RESP;
            end else begin
              wdog_cnt   <= '0;
              rem_en     <= 1'b1;
              state      <= BUSY;
            end
          end
        end

        BUSY: begin
          wdog_cnt <= wdog_next;
          if (rem_valid_i) begin
            rem_en <= 1'b0;
            if (flush_i) begin
              state <= IDLE;
            end else begin
              rsp_result <= rem_result_i;
              rsp_valid  <= 1'b1;
              state      <= RESP;
            end
          end else if (wdog_expire) begin
            err    <= 1'b1;
            rem_en <= 1'b0;
            state  <= ERR;
          end else if (flush_i) begin
            state <= DRAIN;
          end
        end

        DRAIN: begin
          wdog_cnt <= wdog_next;
          if (rem_valid_i) begin
            rem_en <= 1'b0;
            state  <= IDLE;
          end else if (wdog_expire) begin
            err    <= 1'b1;
            rem_en <= 1'b0;
            state  <= ERR;
          end
        end

        RESP: begin
          if (flush_i || rsp_ready_i) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        ERR: begin
          state <= ERR;
        end

        default: begin
          rem_en    <= 1'b0;
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  // Output mapping and the shared 34-bit adder used by the unit
  always_comb begin
    rem_en_o            = rem_en;
    rsp_valid_o         = rsp_valid;
    rsp_result_o        = rsp_result;
    err_o               = err;
    rem_op_a_o          = op_a;
    rem_op_b_o          = op_b;
    rem_signed_mode_o   = {op_signed, op_signed};
    rem_equal_to_zero_o = (op_b == '0);
    rem_alu_adder_ext_o = {1'b0, rem_alu_operand_a_i} + {1'b0, rem_alu_operand_b_i};
    rem_alu_adder_o     = rem_alu_adder_ext_o[32:1];
  end

endmodule

// File: tb/tb_rem_issue_ctrl.sv
// tb_rem_issue_ctrl: directed test of rem_issue_ctrl with a behavioural
// remainder-unit stub and a queue-based response scoreboard.
module tb_rem_issue_ctrl;

  logic        clk_i;
  logic        rst_ni;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] req_op_a_i;
  logic [31:0] req_op_b_i;
  logic        req_signed_i;
  logic        flush_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_result_o;
  logic        err_o;
  logic        rem_en_o;
  logic [1:0]  rem_signed_mode_o;
  logic [31:0] rem_op_a_o;
  logic [31:0] rem_op_b_o;
  logic        rem_equal_to_zero_o;
  logic [32:0] rem_alu_operand_a_i;
  logic [32:0] rem_alu_operand_b_i;
  logic [33:0] rem_alu_adder_ext_o;
  logic [31:0] rem_alu_adder_o;
  logic [31:0] rem_result_i;
  logic        rem_valid_i;

  rem_issue_ctrl dut (
    .clk_i               (clk_i),
    .rst_ni              (rst_ni),
    .req_valid_i         (req_valid_i),
    .req_ready_o         (req_ready_o),
    .req_op_a_i          (req_op_a_i),
    .req_op_b_i          (req_op_b_i),
    .req_signed_i        (req_signed_i),
    .flush_i             (flush_i),
    .rsp_valid_o         (rsp_valid_o),
    .rsp_ready_i         (rsp_ready_i),
    .rsp_result_o        (rsp_result_o),
    .err_o               (err_o),
    .rem_en_o            (rem_en_o),
    .rem_signed_mode_o   (rem_signed_mode_o),
    .rem_op_a_o          (rem_op_a_o),
    .rem_op_b_o          (rem_op_b_o),
    .rem_equal_to_zero_o (rem_equal_to_zero_o),
    .rem_alu_operand_a_i (rem_alu_operand_a_i),
    .rem_alu_operand_b_i (rem_alu_operand_b_i),
    .rem_alu_adder_ext_o (rem_alu_adder_ext_o),
    .rem_alu_adder_o     (rem_alu_adder_o),
    .rem_result_i        (rem_result_i),
    .rem_valid_i         (rem_valid_i)
  );

  typedef struct {
    logic [31:0] result;
    int          cycle;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   stub_lat = 10;
  bit   stub_hang = 1'b0;
  int   en_cnt   = 0;
  bit   en_seen  = 1'b0;
  bit   rsp_seen = 1'b0;

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // cycle index, advanced on each active edge
  always @(posedge clk_i) cyc <= cyc + 1;

  // hard stop in case something hangs outside the bounded waits
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation time exceeded, required finish");
    $fatal(1, "[TB] global timeout");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
               name, actual, expected, cyc);
    end
  endtask

  function automatic logic [31:0] stubRem(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
    if (b == 32'h0) return a;
    if (s) begin
      if (b == 32'hFFFF_FFFF) return 32'h0;
      return 32'($signed(a) % $signed(b));
    end
    return a % b;
  endfunction

  // remainder unit stub: completes after stub_lat enabled cycles unless hung
  always @(negedge clk_i) begin
    if (rem_en_o) begin
      en_cnt  = en_cnt + 1;
      en_seen = 1'b1;
      if (!stub_hang && en_cnt == stub_lat) begin
        rem_valid_i  = 1'b1;
        rem_result_i = stubRem(rem_op_a_o, rem_op_b_o, rem_signed_mode_o[0]);
      end else begin
        rem_valid_i = 1'b0;
      end
    end else begin
      en_cnt      = 0;
      rem_valid_i = 1'b0;
    end
  end

  // response monitor: pops one expectation per response and checks value and timing
  always @(negedge clk_i) begin
    exp_t e;
    if (rst_ni && rsp_valid_o) begin
      if (!rsp_seen) begin
        rsp_seen = 1'b1;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL unexpected_rsp: got response 0x%0h, required none (cycle %0d)",
                   rsp_result_o, cyc);
        end else begin
          e = exp_q.pop_front();
          checkOutput("rsp_result", rsp_result_o, e.result);
          checkOutput("rsp_cycle", cyc, e.cycle);
        end
      end
    end else begin
      rsp_seen = 1'b0;
    end
  end

  // issue one request at a negedge; returns at the negedge of the cycle after accept
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic s,
                               input bit expect_rsp, input logic [31:0] exp_res,
                               input int lat);
    exp_t e;
    req_valid_i  = 1'b1;
    req_op_a_i   = a;
    req_op_b_i   = b;
    req_signed_i = s;
    #1;
    checkOutput("req_ready_at_issue", req_ready_o, 1);
    if (expect_rsp) begin
      e.result = exp_res;
      e.cycle  = cyc + lat;
      exp_q.push_back(e);
    end
    @(negedge clk_i);
    req_valid_i = 1'b0;
  endtask

  task automatic waitIdle();
    int n = 0;
    while (!(req_ready_o && !rsp_valid_o && exp_q.size() == 0) && n < 300) begin
      @(negedge clk_i);
      n++;
    end
    checkOutput("wait_idle_in_budget", (n < 300), 1);
  endtask

  initial begin
    int n;
    rst_ni              = 1'b0;
    req_valid_i         = 1'b0;
    req_op_a_i          = '0;
    req_op_b_i          = '0;
    req_signed_i        = 1'b0;
    flush_i             = 1'b0;
    rsp_ready_i         = 1'b1;
    rem_alu_operand_a_i = '0;
    rem_alu_operand_b_i = '0;
    rem_result_i        = '0;
    rem_valid_i         = 1'b0;

    repeat (3) @(negedge clk_i);
    checkOutput("reset_rsp_valid", rsp_valid_o, 0);
    checkOutput("reset_err", err_o, 0);
    checkOutput("reset_rem_en", rem_en_o, 0);
    rst_ni = 1'b1;
    @(negedge clk_i);
    checkOutput("reset_req_ready", req_ready_o, 1);
    checkOutput("reset_rsp_result", rsp_result_o, 0);
    checkOutput("reset_op_a", rem_op_a_o, 0);
    checkOutput("reset_op_b", rem_op_b_o, 0);
    checkOutput("reset_eq_zero", rem_equal_to_zero_o, 1);

    // adder: zero-extended 34-bit sum, [32:1] slice
    rem_alu_operand_a_i = 33'h0_0000_0006;
    rem_alu_operand_b_i = 33'h0_0000_0004;
    #1;
    checkOutput("adder_ext_small", rem_alu_adder_ext_o, 34'h0_0000_000A);
    checkOutput("adder_small", rem_alu_adder_o, 32'h0000_0005);
    rem_alu_operand_a_i = 33'h1_FFFF_FFFF;
    rem_alu_operand_b_i = 33'h0_0000_0001;
    #1;
    checkOutput("adder_ext_carry", rem_alu_adder_ext_o, 34'h2_0000_0000);
    checkOutput("adder_carry", rem_alu_adder_o, 32'h0000_0000);
    rem_alu_operand_b_i = 33'h1_FFFF_FFFF;
    #1;
    checkOutput("adder_ext_max", rem_alu_adder_ext_o, 34'h3_FFFF_FFFE);
    checkOutput("adder_max", rem_alu_adder_o, 32'hFFFF_FFFF);
    @(negedge clk_i);

    // REMU 7 % 3 = 1, unit done after 10 enabled cycles
    $display("[TB] REMU/REM miss cases");
    stub_lat = 10;
    applyStimulus(32'd7, 32'd3, 1'b0, 1, 32'd1, 11);
    checkOutput("rem_en_at_t1", rem_en_o, 1);
    checkOutput("op_a_latched", rem_op_a_o, 32'd7);
    checkOutput("op_b_latched", rem_op_b_o, 32'd3);
    checkOutput("sign_mode_remu", rem_signed_mode_o, 2'b00);
    waitIdle();
    checkOutput("rem_en_low_after", rem_en_o, 0);

    stub_lat = 8;
    applyStimulus(32'hFFFF_FFF9, 32'd2, 1'b1, 1, 32'hFFFF_FFFF, 9);
    checkOutput("sign_mode_rem", rem_signed_mode_o, 2'b11);
    waitIdle();
    applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1, 32'h0000_0000, 9);
    waitIdle();

    // divide by zero: two enabled cycles, response at T+3
    stub_lat = 2;
    applyStimulus(32'd5, 32'd0, 1'b1, 1, 32'd5, 3);
    checkOutput("eq_zero_flag", rem_equal_to_zero_o, 1);
    waitIdle();

    // cache: miss, then identical hit, then signedness change misses
    $display("[TB] cache hit/miss");
    stub_lat = 10;
    applyStimulus(32'd7, 32'd3, 1'b0, 1, 32'd1, 11);
    waitIdle();
    en_seen = 1'b0;
    applyStimulus(32'd7, 32'd3, 1'b0, 1, 32'd1, 1);
    waitIdle();
    checkOutput("hit_no_rem_en", en_seen, 0);
    applyStimulus(32'd7, 32'd3, 1'b1, 1, 32'd1, 11);
    waitIdle();
    checkOutput("signed_change_miss", en_seen, 1);

    // flush 10 cycles into BUSY: drain without response, then resubmit hits
    $display("[TB] flush and drain");
    stub_lat = 20;
    applyStimulus(32'd100, 32'd7, 1'b0, 0, 32'd0, 0);
    repeat (9) @(negedge clk_i);
    flush_i = 1'b1;
    #1;
    checkOutput("ready_low_under_flush", req_ready_o, 0);
    @(negedge clk_i);
    flush_i = 1'b0;
    checkOutput("drain_rem_en_held", rem_en_o, 1);
    n = 0;
    while (n < 100) begin
      @(negedge clk_i);
      #1;
      if (rem_valid_i) break;
      n++;
    end
    checkOutput("drain_done_in_budget", (n < 100), 1);
    @(negedge clk_i);
    checkOutput("ready_after_drain", req_ready_o, 1);
    checkOutput("no_rsp_after_drain", rsp_valid_o, 0);
    en_seen = 1'b0;
    applyStimulus(32'd100, 32'd7, 1'b0, 1, 32'd2, 1);
    waitIdle();
    checkOutput("drain_refill_hit", en_seen, 0);

    // response back-pressure: outputs held for 5 cycles
    $display("[TB] response hold");
    rsp_ready_i = 1'b0;
    stub_lat = 5;
    applyStimulus(32'd50, 32'd9, 1'b0, 1, 32'd5, 6);
    n = 0;
    while (!rsp_valid_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    repeat (5) begin
      checkOutput("hold_valid", rsp_valid_o, 1);
      checkOutput("hold_result", rsp_result_o, 32'd5);
      checkOutput("hold_ready_low", req_ready_o, 0);
      @(negedge clk_i);
    end
    rsp_ready_i = 1'b1;
    waitIdle();

    // watchdog: unit never completes
    $display("[TB] watchdog");
    stub_hang = 1'b1;
    applyStimulus(32'd9, 32'd4, 1'b0, 0, 32'd0, 0);
    n = 0;
    while (rem_en_o && n < 200) begin
      n++;
      @(negedge clk_i);
    end
    checkOutput("wdog_en_cycles", n, 63);
    checkOutput("wdog_err", err_o, 1);
    checkOutput("wdog_rem_en_low", rem_en_o, 0);
    req_valid_i = 1'b1;
    repeat (3) begin
      @(negedge clk_i);
      checkOutput("err_no_accept", req_ready_o, 0);
    end
    checkOutput("err_no_rsp", rsp_valid_o, 0);
    checkOutput("err_sticky", err_o, 1);
    req_valid_i = 1'b0;

    // reset clears error and cache
    $display("[TB] reset recovery");
    rst_ni = 1'b0;
    #1;
    checkOutput("reset_clears_err", err_o, 0);
    checkOutput("reset_ready_async", req_ready_o, 1);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni    = 1'b1;
    stub_hang = 1'b0;
    stub_lat  = 10;
    @(negedge clk_i);
    en_seen = 1'b0;
    applyStimulus(32'd7, 32'd3, 1'b0, 1, 32'd1, 11);
    waitIdle();
    checkOutput("cache_cleared_by_reset", en_seen, 1);

    checkOutput("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
